// File: rtl/mat_operand_loader.sv
// ============================================================================
// mat_operand_loader : streams A then B (row-major, 4-bit beats) into two
// frozen flattened operand buses for the 4x4 matrix multiplier.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module mat_operand_loader #(
  parameter int ELEM_W = 4,
  parameter int DIM    = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      flush,
  input  logic [ELEM_W-1:0]         in_data,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic                      mat_ack,
  output logic                      mat_valid,
  output logic [DIM*DIM*ELEM_W-1:0] a_flat,
  output logic [DIM*DIM*ELEM_W-1:0] b_flat,
  output logic [5:0]                fill_count
);

  localparam int IDX_W = $clog2(DIM*DIM);
  localparam int LSB_W = $clog2(DIM*DIM*ELEM_W);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DIM*DIM-1);

  typedef enum logic [1:0] {
    LOAD_A = 2'd0,
    LOAD_B = 2'd1,
    HOLD   = 2'd2
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic [LSB_W-1:0] elem_lsb;
  logic             accept;

  assign accept   = in_valid && in_ready;
  assign elem_lsb = LSB_W'(idx) * LSB_W'(ELEM_W);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= LOAD_A;
      idx        <= '0;
      fill_count <= '0;
      in_ready   <= 1'b0;
      mat_valid  <= 1'b0;
      a_flat     <= '0;
      b_flat     <= '0;
    end else if (flush) begin
      // Abort wins over any beat or ack this cycle; operands are left as-is.
      state      <= LOAD_A;
      idx        <= '0;
      fill_count <= '0;
      in_ready   <= 1'b1;
      mat_valid  <= 1'b0;
    end else begin
      unique case (state)
        LOAD_A: begin
          // Also raises in_ready on the first edge out of reset.
          in_ready <= 1'b1;
          if (accept) begin
            a_flat[elem_lsb +: ELEM_W] <= in_data;
            idx        <= idx + IDX_W'(1);
            fill_count <= fill_count + 6'd1;
            if (idx == LAST_IDX) begin
              state <= LOAD_B;
            end
          end
        end
        LOAD_B: begin
          if (accept) begin
            b_flat[elem_lsb +: ELEM_W] <= in_data;
            idx        <= idx + IDX_W'(1);
            fill_count <= fill_count + 6'd1;
            if (idx == LAST_IDX) begin
              state     <= HOLD;
              mat_valid <= 1'b1;
              in_ready  <= 1'b0;
            end
          end
        end
        HOLD: begin
          if (mat_ack) begin
            state      <= LOAD_A;
            idx        <= '0;
            fill_count <= '0;
            mat_valid  <= 1'b0;
            in_ready   <= 1'b1;
          end
        end
        default: begin
          state <= LOAD_A;
        end
      endcase
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_mat_operand_loader.sv
// ============================================================================
// tb_mat_operand_loader : directed self-checking bench for mat_operand_loader.
// Revision 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mat_operand_loader;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic [3:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        mat_ack;
  logic        mat_valid;
  logic [63:0] a_flat;
  logic [63:0] b_flat;
  logic [5:0]  fill_count;

  int pass_cnt = 0;
  int fail_cnt = 0;
  int total    = 0;

  localparam logic [63:0] A_RAMP  = 64'hFEDCBA9876543210;
  localparam logic [63:0] B_IDENT = 64'h1000010000100001;

  mat_operand_loader #(.ELEM_W(4), .DIM(4)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .flush      (flush),
    .in_data    (in_data),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .mat_ack    (mat_ack),
    .mat_valid  (mat_valid),
    .a_flat     (a_flat),
    .b_flat     (b_flat),
    .fill_count (fill_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) pass_cnt++;
    else begin
      fail_cnt++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic beat(input logic [3:0] d);
    in_valid = 1'b1;
    in_data  = d;
    step();
    in_valid = 1'b0;
  endtask

  // Identity-test data: A element k = k, B = identity matrix.
  function automatic logic [3:0] ident_val(input int k);
    if (k < 16) return 4'(k);
    return ((k - 16) % 5 == 0) ? 4'd1 : 4'd0;
  endfunction

  initial begin
    rst_n    = 1'b0;
    flush    = 1'b0;
    in_valid = 1'b0;
    in_data  = 4'h0;
    mat_ack  = 1'b0;

    #2;
    chk("rst_in_ready",  in_ready,   0);
    chk("rst_mat_valid", mat_valid,  0);
    chk("rst_fill",      fill_count, 0);
    chk("rst_a",         a_flat,     0);
    chk("rst_b",         b_flat,     0);

    step();
    step();
    #3 rst_n = 1'b1;
    // A beat offered on the first edge after release must not be taken.
    in_valid = 1'b1;
    in_data  = 4'hF;
    step();
    in_valid = 1'b0;
    chk("post_rst_ready", in_ready,   1);
    chk("post_rst_fill",  fill_count, 0);
    chk("post_rst_a",     a_flat,     0);

    // Full-rate identity load, with a stray ack during A beat 3.
    for (int k = 0; k < 32; k++) begin
      mat_ack = (k == 3);
      beat(ident_val(k));
      mat_ack = 1'b0;
      if (k == 3)  chk("ack_outside_hold_fill", fill_count, 4);
      if (k == 15) chk("fill_after_a", fill_count, 16);
      if (k == 30) chk("valid_before_last", mat_valid, 0);
    end
    chk("ident_valid", mat_valid,  1);
    chk("ident_ready", in_ready,   0);
    chk("ident_fill",  fill_count, 32);
    chk("ident_a",     a_flat,     A_RAMP);
    chk("ident_b",     b_flat,     B_IDENT);

    // Beats offered in HOLD are ignored.
    in_valid = 1'b1;
    in_data  = 4'h5;
    repeat (10) step();
    chk("hold_a",     a_flat,     A_RAMP);
    chk("hold_b",     b_flat,     B_IDENT);
    chk("hold_valid", mat_valid,  1);
    chk("hold_fill",  fill_count, 32);

    in_valid = 1'b0;
    mat_ack  = 1'b1;
    step();
    mat_ack = 1'b0;
    chk("ack_valid", mat_valid,  0);
    chk("ack_ready", in_ready,   1);
    chk("ack_fill",  fill_count, 0);
    chk("ack_a",     a_flat,     A_RAMP);

    beat(4'h7);
    chk("reload_a0",   a_flat,     64'hFEDCBA9876543217);
    chk("reload_fill", fill_count, 1);

    // Partial load to 20 beats, then flush alongside a valid beat.
    for (int k = 1; k < 20; k++) beat(4'h3);
    chk("pre_flush_fill", fill_count, 20);
    chk("pre_flush_a",    a_flat,     64'h3333333333333337);

    in_valid = 1'b1;
    in_data  = 4'hA;
    flush    = 1'b1;
    step();
    flush    = 1'b0;
    in_valid = 1'b0;
    chk("flush_fill",  fill_count, 0);
    chk("flush_ready", in_ready,   1);
    chk("flush_valid", mat_valid,  0);
    chk("flush_a",     a_flat,     64'h3333333333333337);
    chk("flush_b",     b_flat,     64'h1000010000103333);

    // Bubbly source: valid pattern 1,0,0 repeated.
    for (int k = 0; k < 32; k++) begin
      beat(ident_val(k));
      chk("bub_fill",  fill_count, 64'(k + 1));
      chk("bub_valid", mat_valid,  (k == 31) ? 64'd1 : 64'd0);
      if (k < 31) begin
        step();
        step();
        if (k == 10) chk("bub_stall_fill", fill_count, 11);
      end
    end
    chk("bub_a",    a_flat,     A_RAMP);
    chk("bub_b",    b_flat,     B_IDENT);
    chk("bub_ready", in_ready,  0);

    // Asynchronous reset while holding.
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", mat_valid,  0);
    chk("arst_ready", in_ready,   0);
    chk("arst_fill",  fill_count, 0);
    chk("arst_a",     a_flat,     0);
    chk("arst_b",     b_flat,     0);
    #3 rst_n = 1'b1;
    step();
    chk("arst_rel_ready", in_ready,   1);
    chk("arst_rel_fill",  fill_count, 0);
    chk("arst_rel_valid", mat_valid,  0);

    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule

`default_nettype wire
